counter_mod: RTL and testbench

Parametrised synchronous modulo-N up/down counter; successor to the fixed 4-bit ripple counter. All bits change on the single `clock` edge, so there is no ripple skew. Adds direction control, parallel load, synchronous clear, terminal-count and wrap outputs, and a sticky overflow flag. Used for move timers, clock-divider ticks and board-index sequencing throughout the chess datapath.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_mod_step.sv | 46 ++++
 rtl/counter_mod.sv | 89 ++++++++
 tb/tb_counter_mod.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and parameter-legality check for counter variants
`ifndef COUNTER_PKG_SV
`define COUNTER_PKG_SV

// Elaboration-time legality check shared by every counter variant.
// Use it at module scope, after the parameters are declared.
`define COUNTER_PARAM_CHECK(W, M, R) \
  if (((W) < 1) || ((W) > counter_pkg::MAX_COUNTER_WIDTH) || ((M) < 2) || \
      ((M) > (64'd1 << (W))) || ((R) >= (M))) begin : g_param_err \
    $error("counter: illegal WIDTH/MODULO/RESET_VAL combination"); \
  end

package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MAX_COUNTER_WIDTH = 32;

endpackage

`endif

// File: rtl/counter_mod_step.sv
// rtl/counter_mod_step.sv - combinational next-count and terminal-step logic
module counter_mod_step
  import counter_pkg::*;
#(
  parameter int              WIDTH  = 4,
  parameter longint unsigned MODULO = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             sat_en,
  output logic [WIDTH-1:0] next_count,
  output logic             is_terminal
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);

  // One extra bit keeps MODULO == 2^WIDTH free of special cases.
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  // Step one position in the selected direction, wrapping or saturating at the ends
  always_comb begin
    inc         = {1'b0, count} + (WIDTH+1)'(1);
    dec         = {1'b0, count} - (WIDTH+1)'(1);
    next_count  = count;
    is_terminal = 1'b0;
    if (up == DIR_UP) begin
      is_terminal = (inc == MOD_EXT);
      if (is_terminal) begin
        next_count = sat_en ? MAX_V : '0;
      end else begin
        next_count = inc[WIDTH-1:0];
      end
    end else begin
      // A borrow out of the top bit means count was zero.
      is_terminal = dec[WIDTH];
      if (is_terminal) begin
        next_count = sat_en ? '0 : MAX_V;
      end else begin
        next_count = dec[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/counter_mod.sv
// rtl/counter_mod.sv - modulo-N up/down counter; COUNTER_MOD_SATURATE_EN selects saturate mode
module counter_mod
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MODULO    = 16,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             enable,
  input  logic             up,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  `COUNTER_PARAM_CHECK(WIDTH, MODULO, RESET_VAL)

  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);

`ifdef COUNTER_MOD_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_count;
  logic             step_term;

  counter_mod_step #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_step (
    .count       (count_q),
    .up          (up),
    .sat_en      (SAT_EN),
    .next_count  (step_count),
    .is_terminal (step_term)
  );

  // Terminal count is unregistered so it can feed the next stage's enable this cycle
  assign tc    = enable & step_term;
  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

  // Priority mux: sclr, then load (clamped to MODULO-1), then count step, then hold
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (sclr) begin
      count_d = RST_V;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_V;
    end else if (enable) begin
      count_d = step_count;
      if (step_term) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end
    end
  end

  // Count, wrap and overflow registers with asynchronous clear
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= RST_V;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_counter_mod.sv
// tb/tb_counter_mod.sv - directed bench for counter_mod (mod-10 and mod-16 instances)
module tb_counter_mod;

  logic       clock = 1'b0;
  logic       clr_n;
  logic       enable;
  logic       up;
  logic       sclr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] count10, count16;
  logic       tc10, tc16, wrap10, wrap16, ovf10, ovf16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  counter_mod #(.WIDTH(4), .MODULO(10), .RESET_VAL(3)) u_dut10 (
    .clock    (clock),
    .clr_n    (clr_n),
    .enable   (enable),
    .up       (up),
    .sclr     (sclr),
    .load     (load),
    .load_val (load_val),
    .count    (count10),
    .tc       (tc10),
    .wrap     (wrap10),
    .ovf      (ovf10)
  );

  counter_mod #(.WIDTH(4), .MODULO(16), .RESET_VAL(0)) u_dut16 (
    .clock    (clock),
    .clr_n    (clr_n),
    .enable   (enable),
    .up       (up),
    .sclr     (sclr),
    .load     (load),
    .load_val (load_val),
    .count    (count16),
    .tc       (tc16),
    .wrap     (wrap16),
    .ovf      (ovf16)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle just past it before checking/driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clr_n    = 1'b0;
    enable   = 1'b0;
    up       = 1'b1;
    sclr     = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    #12;
    check("rst_count", count10, 4'd3);
    check("rst_wrap",  {3'b0, wrap10}, 4'd0);
    check("rst_ovf",   {3'b0, ovf10}, 4'd0);
    check("rst_tc",    {3'b0, tc10}, 4'd0);
    clr_n = 1'b1;

    // Asynchronous clear from count=7, mid-cycle
    tick();
    load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0;
    check("pre_async_count", count10, 4'd7);
    #2;
    clr_n = 1'b0;
    #1;
    check("async_count", count10, 4'd3);
    check("async_wrap",  {3'b0, wrap10}, 4'd0);
    check("async_ovf",   {3'b0, ovf10}, 4'd0);
    clr_n = 1'b1;

`ifndef COUNTER_MOD_SATURATE_EN
    // Up wrap: 8 -> 9 -> 0 -> 1
    tick();
    load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; enable = 1'b1; up = 1'b1;
    check("up_tc_at8", {3'b0, tc10}, 4'd0);
    tick();
    check("up_count9", count10, 4'd9);
    check("up_tc_at9", {3'b0, tc10}, 4'd1);
    check("up_wrap_at9", {3'b0, wrap10}, 4'd0);
    tick();
    check("up_count0", count10, 4'd0);
    check("up_wrap_at0", {3'b0, wrap10}, 4'd1);
    check("up_ovf_at0", {3'b0, ovf10}, 4'd1);
    check("up_tc_at0", {3'b0, tc10}, 4'd0);
    tick();
    check("up_count1", count10, 4'd1);
    check("up_wrap_at1", {3'b0, wrap10}, 4'd0);
    check("up_ovf_sticky", {3'b0, ovf10}, 4'd1);

    // Down wrap: 1 -> 0 -> 9 (direction change is continuous)
    up = 1'b0;
    tick();
    check("dn_count0", count10, 4'd0);
    check("dn_wrap_at0", {3'b0, wrap10}, 4'd0);
    check("dn_tc_at0", {3'b0, tc10}, 4'd1);
    tick();
    check("dn_count9", count10, 4'd9);
    check("dn_wrap_at9", {3'b0, wrap10}, 4'd1);
    enable = 1'b0;
    tick();
    check("dn_hold9", count10, 4'd9);
    check("dn_wrap_cleared", {3'b0, wrap10}, 4'd0);
    check("dn_tc_disabled", {3'b0, tc10}, 4'd0);

    // Load clamp with ovf already set, load beating enable
    up = 1'b1; enable = 1'b1; load = 1'b1; load_val = 4'd12;
    tick();
    check("clamp_count", count10, 4'd9);
    check("clamp_ovf_kept", {3'b0, ovf10}, 4'd1);
    check("clamp_wrap", {3'b0, wrap10}, 4'd0);

    // sclr beats load and enable
    sclr = 1'b1; load = 1'b1; load_val = 4'd5; enable = 1'b1;
    tick();
    sclr = 1'b0; enable = 1'b0;
    check("sclr_count", count10, 4'd3);
    check("sclr_ovf", {3'b0, ovf10}, 4'd0);
    check("sclr_wrap", {3'b0, wrap10}, 4'd0);
    load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    check("clamp2_count", count10, 4'd9);
    check("clamp2_ovf", {3'b0, ovf10}, 4'd0);

    // Full range on the mod-16 instance: 15 -> 0
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    check("full_load15", count16, 4'd15);
    enable = 1'b1; up = 1'b1;
    #1;
    check("full_tc15", {3'b0, tc16}, 4'd1);
    tick();
    enable = 1'b0;
    check("full_count0", count16, 4'd0);
    check("full_known", {3'b0, $isunknown(count16)}, 4'd0);
    check("full_wrap", {3'b0, wrap16}, 4'd1);
    check("full_ovf", {3'b0, ovf16}, 4'd1);
`else
    // Saturate mode: 9 holds, wrap pulses each terminal edge, then step down
    tick();
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; enable = 1'b1; up = 1'b1;
    check("sat_tc9", {3'b0, tc10}, 4'd1);
    tick();
    check("sat_count_a", count10, 4'd9);
    check("sat_wrap_a", {3'b0, wrap10}, 4'd1);
    check("sat_ovf_a", {3'b0, ovf10}, 4'd1);
    tick();
    check("sat_count_b", count10, 4'd9);
    check("sat_wrap_b", {3'b0, wrap10}, 4'd1);
    up = 1'b0;
    tick();
    check("sat_down_count", count10, 4'd8);
    check("sat_down_wrap", {3'b0, wrap10}, 4'd0);
    check("sat_ovf_sticky", {3'b0, ovf10}, 4'd1);
    enable = 1'b0;
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; enable = 1'b1; up = 1'b0;
    tick();
    check("sat_dn_hold0", count10, 4'd0);
    check("sat_dn_wrap", {3'b0, wrap10}, 4'd1);
    enable = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
